// File: rtl/ser_mon_pkg.sv
// Shared types and constants for the serial receive monitor.
package ser_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int MIN_DIV = 4;

endpackage

// File: rtl/ser_mon_fifo.sv
// Show-ahead FIFO: head entry visible combinationally, write visible next cycle.
// A push into a full FIFO without a same-cycle pop is dropped and flagged on drop.
module ser_mon_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign rd_en    = pop & ~empty;
  // When full, a simultaneous pop frees the slot being written.
  assign wr_en    = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ser_rx_monitor.sv
// UART receive monitor: oversampled frame decode into a show-ahead FIFO; entry visible 1 cycle after final stop sample.
// Full FIFO drops frames into sticky overflow; define SER_RX_MON_DISPLAY_EN for simulation-only push printing.
module ser_rx_monitor
  import ser_mon_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ser_line,
  input  logic [DIV_W-1:0]            cfg_div,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_BITS-1:0]        out_data,
  output logic                        out_frame_err,
  output logic                        out_parity_err,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  localparam int ENT_W = DATA_BITS + 2;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_d;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     div_l;
  logic [DIV_W-1:0]     div_eff;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frm_err;
  logic                 push_r;
  logic [ENT_W-1:0]     push_dat;
  logic [ENT_W-1:0]     head_dat;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_drop;
  logic                 expire;

  assign div_eff = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
  assign expire  = (cnt <= DIV_W'(1));
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
      state    <= ST_IDLE;
      cnt      <= '0;
      div_l    <= DIV_W'(MIN_DIV);
      bit_idx  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      push_r   <= 1'b0;
      push_dat <= '0;
    end else begin
      rx_meta <= ser_line;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      push_r  <= 1'b0;
      if (state != ST_IDLE && state != ST_BREAK)
        cnt <= expire ? div_l : cnt - DIV_W'(1);
      case (state)
        ST_IDLE: begin
          if (rx_d && !rx_s) begin
            div_l   <= div_eff;
            cnt     <= div_eff >> 1;
            bit_idx <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (expire) state <= rx_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (expire) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (expire) begin
            par_err <= ((^shreg) ^ rx_s) != (PARITY == PAR_ODD);
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (expire) begin
            if (bit_idx == 4'(STOP_BITS - 1)) begin
              push_r   <= 1'b1;
              push_dat <= {frm_err | ~rx_s, par_err, shreg};
              state    <= (frm_err | ~rx_s) ? ST_BREAK : ST_IDLE;
            end else begin
              frm_err <= frm_err | ~rx_s;
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        ST_BREAK: begin
          // A held-low line must go high before another start bit is accepted.
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ser_mon_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_r),
    .push_dat (push_dat),
    .pop      (out_ready),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .drop     (fifo_drop)
  );

  assign out_valid      = ~fifo_empty;
  assign out_frame_err  = head_dat[ENT_W-1];
  assign out_parity_err = head_dat[ENT_W-2];
  assign out_data       = head_dat[DATA_BITS-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (fifo_drop)    overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

`ifdef SER_RX_MON_DISPLAY_EN
  always @(posedge clk) begin
    if (!reset && push_r) begin
      if (push_dat[DATA_BITS-1:0] >= 32 && push_dat[DATA_BITS-1:0] <= 126 &&
          !push_dat[ENT_W-1] && !push_dat[ENT_W-2])
        $display("Serial data: '%c'", push_dat[7:0]);
      else
        $display("Serial data: %d%s%s", push_dat[DATA_BITS-1:0],
                 push_dat[ENT_W-1] ? " FRAME_ERR" : "",
                 push_dat[ENT_W-2] ? " PARITY_ERR" : "");
      if (fifo_drop) $display("Serial overflow");
    end
  end
`else
`endif

endmodule

// File: tb/tb_ser_rx_monitor.sv
// Directed bench: instance a is 8N1 depth 16, instance b is 8E2 depth 4.
module tb_ser_rx_monitor;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        line_a, line_b;
  logic [15:0] div_a, div_b;
  logic        rdy_a, rdy_b;
  logic        clr_a, clr_b;
  logic        vld_a, vld_b;
  logic [7:0]  dat_a, dat_b;
  logic        fe_a, fe_b, pe_a, pe_b;
  logic        ovf_a, ovf_b;
  logic [4:0]  lvl_a;
  logic [2:0]  lvl_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  ser_rx_monitor u_a (
    .clk(clk), .reset(rst_a), .ser_line(line_a), .cfg_div(div_a),
    .out_valid(vld_a), .out_ready(rdy_a), .out_data(dat_a),
    .out_frame_err(fe_a), .out_parity_err(pe_a), .overflow(ovf_a),
    .clr_overflow(clr_a), .fifo_level(lvl_a), .busy(busy_a)
  );

  ser_rx_monitor #(.PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(rst_b), .ser_line(line_b), .cfg_div(div_b),
    .out_valid(vld_b), .out_ready(rdy_b), .out_data(dat_b),
    .out_frame_err(fe_b), .out_parity_err(pe_b), .overflow(ovf_b),
    .clr_overflow(clr_b), .fifo_level(lvl_b), .busy(busy_b)
  );

  task automatic tick(input int cyc);
    repeat (cyc) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int val, input int lo, input int hi);
    checks++;
    assert (((val >= lo) && (val <= hi)) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) line_a = v;
    else           line_b = v;
  endtask

  task automatic send(input int inst, input int div, input logic [7:0] d, input bit par_en,
                      input bit par_bit, input int nstop, input bit stop_val);
    set_line(inst, 1'b0);
    tick(div);
    for (int i = 0; i < 8; i++) begin
      set_line(inst, d[i]);
      tick(div);
    end
    if (par_en) begin
      set_line(inst, par_bit);
      tick(div);
    end
    for (int i = 0; i < nstop; i++) begin
      set_line(inst, stop_val);
      tick(div);
    end
  endtask

  task automatic pop_b();
    rdy_b = 1'b1;
    tick(1);
    rdy_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    rst_a = 1'b1; rst_b = 1'b1;
    line_a = 1'b1; line_b = 1'b1;
    div_a = 16'd106; div_b = 16'd8;
    rdy_a = 1'b0; rdy_b = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    tick(3);
    check("rst_valid", vld_a, 0);
    check("rst_level", lvl_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_data", dat_a, 0);
    check("rst_flags", {fe_a, pe_a}, 0);
    check("rst_b_level", lvl_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(3);

    // 8N1 0x41 with consumer always ready
    rdy_a = 1'b1;
    fork
      send(0, 106, 8'h41, 0, 0, 1, 1'b1);
      begin
        n = 0;
        while (!vld_a && n < 1300) begin
          tick(1);
          n++;
        end
        check_rng("a41_latency", n, 1005, 1070);
        check("a41_data", dat_a, 8'h41);
        check("a41_flags", {fe_a, pe_a}, 0);
        tick(1);
        check("a41_popped_valid", vld_a, 0);
        check("a41_popped_level", lvl_a, 0);
      end
    join
    rdy_a = 1'b0;
    tick(20);

    // 20-cycle glitch must be rejected at the mid-start resample
    fork
      begin
        line_a = 1'b0;
        tick(20);
        line_a = 1'b1;
      end
      begin
        tick(5);
        check("glitch_busy", busy_a, 1);
        n = 5;
        while (busy_a && n < 200) begin
          tick(1);
          n++;
        end
        check_rng("glitch_busy_len", n, 54, 60);
      end
    join
    tick(10);
    check("glitch_level", lvl_a, 0);
    check("glitch_valid", vld_a, 0);

    // Low stop bit then line held low: single frame-error entry, no retrigger
    send(0, 106, 8'h3C, 0, 0, 1, 1'b0);
    tick(2000);
    check("brk_valid", vld_a, 1);
    check("brk_data", dat_a, 8'h3C);
    check("brk_frame_err", fe_a, 1);
    check("brk_parity_err", pe_a, 0);
    check("brk_busy", busy_a, 1);
    line_a = 1'b1;
    tick(300);
    check("brk_level", lvl_a, 1);
    check("brk_idle", busy_a, 0);
    rdy_a = 1'b1; tick(1); rdy_a = 1'b0;
    check("brk_drained", lvl_a, 0);
    send(0, 106, 8'h55, 0, 0, 1, 1'b1);
    tick(10);
    check("a55_valid", vld_a, 1);
    check("a55_data", dat_a, 8'h55);
    check("a55_flags", {fe_a, pe_a}, 0);

    // Even parity, two stop bits
    send(1, 8, 8'h03, 1, 1, 2, 1'b1);
    tick(4);
    check("par1_data", dat_b, 8'h03);
    check("par1_perr", pe_b, 1);
    check("par1_ferr", fe_b, 0);
    pop_b();
    send(1, 8, 8'h03, 1, 0, 2, 1'b1);
    tick(4);
    check("par0_data", dat_b, 8'h03);
    check("par0_perr", pe_b, 0);
    pop_b();
    check("par_drained", lvl_b, 0);

    // Overflow: five frames into a depth-4 FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      d = 8'h10 + 8'(i);
      send(1, 8, d, 1, ^d, 2, 1'b1);
      tick(2);
    end
    check("ovf_level", lvl_b, 4);
    check("ovf_flag", ovf_b, 1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", dat_b, 32'h10 + 32'(i));
      check("ovf_perr", pe_b, 0);
      pop_b();
    end
    check("ovf_empty", vld_b, 0);
    check("ovf_sticky", ovf_b, 1);
    clr_b = 1'b1; tick(1); clr_b = 1'b0;
    check("ovf_cleared", ovf_b, 0);

    // Reset mid-DATA abandons the frame
    fork
      send(1, 8, 8'hA5, 1, 0, 2, 1'b1);
      begin
        tick(30);
        check("rstmid_busy", busy_b, 1);
        rst_b = 1'b1;
      end
    join
    tick(2);
    rst_b = 1'b0;
    tick(3);
    check("rstmid_level", lvl_b, 0);
    check("rstmid_valid", vld_b, 0);
    check("rstmid_busy_after", busy_b, 0);
    send(1, 8, 8'hA5, 1, 0, 2, 1'b1);
    tick(4);
    check("resend_level", lvl_b, 1);
    check("resend_data", dat_b, 8'hA5);
    check("resend_flags", {fe_b, pe_b}, 0);
    pop_b();

    // Divider below minimum behaves as 4 clocks per bit
    div_b = 16'd2;
    send(1, 4, 8'h5A, 1, 0, 2, 1'b1);
    tick(4);
    check("mindiv_level", lvl_b, 1);
    check("mindiv_data", dat_b, 8'h5A);
    check("mindiv_flags", {fe_b, pe_b}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
